// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Purpose  : Iterative radix-2 restoring divider with a parametrised width,
//             per-operation signed/unsigned mode, quotient and remainder
//             outputs, divide-by-zero reporting and valid/ready handshakes
//             on both the operand and the result side.
//             One operation is in flight at a time.
//  Options  : DIV_SEQ_EARLY_TERM_EN - when defined, an operation whose
//             dividend magnitude is below a non-zero divisor magnitude
//             completes on the accepting edge instead of iterating.
//             Results are bit-identical in both builds; only latency moves.
//  Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
  parameter int WIDTH = 32            // legal range 2..64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz
);

  // Iteration counter must be able to hold the value WIDTH itself.
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;

  // Captured operation context.
  logic               sa_q;        // dividend is negative (signed mode only)
  logic               sb_q;        // divisor is negative (signed mode only)
  logic               dbz_q;       // divisor was zero
  logic [WIDTH-1:0]   a_raw_q;     // dividend exactly as presented
  logic [WIDTH-1:0]   bmag_q;      // divisor magnitude

  // Shift register: dividend bits leave at the MSB while quotient bits
  // enter at the LSB, so after WIDTH steps it holds the magnitude quotient.
  logic [WIDTH-1:0]   dvd_q;
  // Partial remainder; always strictly below bmag_q so WIDTH bits suffice
  // between iterations. The widened WIDTH+1 value exists only in rem_cmp_d.
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      cnt_q;

  // Registered outputs.
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_q_q;
  logic [WIDTH-1:0]   out_r_q;
  logic               out_dbz_q;

  // Operand magnitudes at the accepting edge.
  logic               in_sa_d;
  logic               in_sb_d;
  logic [WIDTH-1:0]   amag_d;
  logic [WIDTH-1:0]   bmag_d;

  // One restoring step.
  logic [WIDTH:0]     rem_cmp_d;
  logic [WIDTH:0]     diff_d;
  logic               ge_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  // Final result formatting.
  logic [WIDTH-1:0]   q_res_d;
  logic [WIDTH-1:0]   r_res_d;

  // Ready is a pure function of state and reset, never of in_valid.
  assign in_ready = (state_q == S_IDLE) & rst_n;

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_r     = out_r_q;
  assign out_dbz   = out_dbz_q;

  // Operand sign detection and magnitude conversion; the most negative value
  // negates onto itself, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    in_sa_d = in_signed & in_a[WIDTH-1];
    in_sb_d = in_signed & in_b[WIDTH-1];
    amag_d  = in_sa_d ? (~in_a + 1'b1) : in_a;
    bmag_d  = in_sb_d ? (~in_b + 1'b1) : in_b;
  end

  // One quotient bit: shift the next dividend bit into the remainder and try
  // the subtraction. The difference can never exceed 2^WIDTH when it is
  // non-negative, so its top bit doubles as the borrow (remainder too small).
  always_comb begin
    rem_cmp_d = {rem_q, dvd_q[WIDTH-1]};
    diff_d    = rem_cmp_d - {1'b0, bmag_q};
    ge_d      = ~diff_d[WIDTH];
    rem_d     = ge_d ? diff_d[WIDTH-1:0] : rem_cmp_d[WIDTH-1:0];
    quo_d     = {dvd_q[WIDTH-2:0], ge_d};
  end

  // Result formatting for the final step: quotient truncates toward zero,
  // remainder follows the dividend sign, divide-by-zero returns all ones and
  // the untouched dividend. Most-negative / -1 wraps naturally.
  always_comb begin
    if (dbz_q) begin
      q_res_d = '1;
      r_res_d = a_raw_q;
    end else begin
      q_res_d = (sa_q ^ sb_q) ? (~quo_d + 1'b1) : quo_d;
      r_res_d = sa_q ? (~rem_d + 1'b1) : rem_d;
    end
  end

  // Control FSM together with the iterative datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dbz_q       <= 1'b0;
      a_raw_q     <= '0;
      bmag_q      <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sa_q    <= in_sa_d;
            sb_q    <= in_sb_d;
            dbz_q   <= (in_b == '0);
            a_raw_q <= in_a;
            bmag_q  <= bmag_d;
            dvd_q   <= amag_d;
            rem_q   <= '0;
            cnt_q   <= CNT_INIT;
`ifdef DIV_SEQ_EARLY_TERM_EN
            // A dividend smaller than the divisor has quotient 0 and the
            // dividend itself as remainder, so the iteration is skipped.
            if ((in_b != '0) && (amag_d < bmag_d)) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_q_q     <= '0;
              out_r_q     <= in_a;
              out_dbz_q   <= 1'b0;
            end else begin
              state_q     <= S_CALC;
            end
`else
            state_q <= S_CALC;
`endif
          end
        end

        S_CALC: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_q_q     <= q_res_d;
            out_r_q     <= r_res_d;
            out_dbz_q   <= dbz_q;
          end
        end

        S_DONE: begin
          // Result data is left in place after the handshake; only the
          // valid flag drops.
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Directed self-checking bench for div_seq at WIDTH=32 and
//             WIDTH=8. Expected latency of the small-dividend case follows
//             DIV_SEQ_EARLY_TERM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

`ifdef DIV_SEQ_EARLY_TERM_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif
  localparam int LAT32 = 33;
  localparam int LAT8  = 9;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic        out_dbz;

  logic        s8_in_valid;
  logic        s8_in_ready;
  logic [7:0]  s8_in_a;
  logic [7:0]  s8_in_b;
  logic        s8_in_signed;
  logic        s8_out_valid;
  logic        s8_out_ready;
  logic [7:0]  s8_out_q;
  logic [7:0]  s8_out_r;
  logic        s8_out_dbz;

  int checks;
  int failures;

  div_seq #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dbz   (out_dbz)
  );

  div_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s8_in_valid),
    .in_ready  (s8_in_ready),
    .in_a      (s8_in_a),
    .in_b      (s8_in_b),
    .in_signed (s8_in_signed),
    .out_valid (s8_out_valid),
    .out_ready (s8_out_ready),
    .out_q     (s8_out_q),
    .out_r     (s8_out_r),
    .out_dbz   (s8_out_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for exactly one edge; operands are scrambled
  // afterwards since the DUT must have captured them at the accepting edge.
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 32'hA5A5_5A5A; in_b = 32'h0000_0001; in_signed = ~s;
  endtask

  // Count edges from the accepting edge (counted as 1) until out_valid.
  task automatic wait32(output int lat, output bit saw_ready);
    lat = 1;
    saw_ready = in_ready;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) saw_ready = 1'b1;
    end
  endtask

  task automatic release32();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 32'd0 || out_r !== 32'd0 || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b q=%h r=%h dbz=%b, want 0/0/0/0", out_valid, out_q, out_r, out_dbz);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    bit saw;
    start32(32'd100, 32'd7, 1'b0);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32) begin
      failures++;
      $display("FAIL u100_7_latency: got %0d want %0d", lat, LAT32);
    end
    checks++;
    if (out_q !== 32'd14 || out_r !== 32'd2 || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL u100_7_result: got q=%0d r=%0d dbz=%b want 14 2 0", out_q, out_r, out_dbz);
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL busy_in_ready: got in_ready=1 while busy, want 0");
    end
    release32();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL u100_7_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    int lat;
    bit saw;
    start32(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'hFFFF_FFFD || out_r !== 32'hFFFF_FFFF || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL s_m7_2: got lat=%0d q=%h r=%h dbz=%b want 33 fffffffd ffffffff 0", lat, out_q, out_r, out_dbz);
    end
    release32();
    start32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'h8000_0000 || out_r !== 32'd0 || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL s_overflow: got lat=%0d q=%h r=%h dbz=%b want 33 80000000 0 0", lat, out_q, out_r, out_dbz);
    end
    release32();
    // Unsigned mode must not treat the MSB as a sign.
    start32(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait32(lat, saw);
    checks++;
    if (out_q !== 32'h7FFF_FFFC || out_r !== 32'd1) begin
      failures++;
      $display("FAIL u_big_2: got q=%h r=%h want 7ffffffc 1", out_q, out_r);
    end
    release32();
  endtask

  task automatic test_dbz();
    int lat;
    bit saw;
    start32(32'd5, 32'd0, 1'b0);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'hFFFF_FFFF || out_r !== 32'd5 || out_dbz !== 1'b1) begin
      failures++;
      $display("FAIL dbz_u5: got lat=%0d q=%h r=%h dbz=%b want 33 ffffffff 5 1", lat, out_q, out_r, out_dbz);
    end
    release32();
    start32(32'hFFFF_FFF9, 32'd0, 1'b1);
    wait32(lat, saw);
    checks++;
    if (out_q !== 32'hFFFF_FFFF || out_r !== 32'hFFFF_FFF9 || out_dbz !== 1'b1) begin
      failures++;
      $display("FAIL dbz_s_m7: got q=%h r=%h dbz=%b want ffffffff fffffff9 1", out_q, out_r, out_dbz);
    end
    release32();
  endtask

  task automatic test_backpressure();
    int lat;
    bit saw;
    int bad;
    start32(32'hFFFF_FFFF, 32'd16, 1'b0);
    wait32(lat, saw);
    checks++;
    if (out_q !== 32'h0FFF_FFFF || out_r !== 32'hF || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL bp_result: got q=%h r=%h dbz=%b want 0fffffff f 0", out_q, out_r, out_dbz);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd9 + 32'(i); in_b = 32'd3; in_signed = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 32'h0FFF_FFFF ||
          out_r !== 32'hF || out_dbz !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0 (valid=%b ready=%b q=%h)", bad, out_valid, in_ready, out_q);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q !== 32'h0FFF_FFFF || out_r !== 32'hF) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b q=%h r=%h want 0 1 0fffffff f", out_valid, in_ready, out_q, out_r);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit saw;
    start32(32'd12345, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 32'd0 || out_r !== 32'd0 || out_dbz !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b q=%h r=%h dbz=%b ready=%b want all 0", out_valid, out_q, out_r, out_dbz, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The aborted operation must never produce a result.
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) saw = 1'b1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_discard: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    start32(32'd1000, 32'd10, 1'b0);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'd100 || out_r !== 32'd0 || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op: got lat=%0d q=%0d r=%0d dbz=%b want 33 100 0 0", lat, out_q, out_r, out_dbz);
    end
    release32();
  endtask

  task automatic test_early_term();
    int lat;
    bit saw;
    start32(32'd3, 32'd10, 1'b0);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT_SMALL) begin
      failures++;
      $display("FAIL small_latency: got %0d want %0d", lat, LAT_SMALL);
    end
    checks++;
    if (out_q !== 32'd0 || out_r !== 32'd3 || out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL small_result: got q=%0d r=%0d dbz=%b want 0 3 0", out_q, out_r, out_dbz);
    end
    release32();
    // Signed small dividend: remainder keeps the dividend's sign.
    start32(32'hFFFF_FFFD, 32'd10, 1'b1);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT_SMALL || out_q !== 32'd0 || out_r !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL small_signed: got lat=%0d q=%h r=%h want %0d 0 fffffffd", lat, out_q, out_r, LAT_SMALL);
    end
    release32();
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    s8_in_a = 8'd200; s8_in_b = 8'd7; s8_in_signed = 1'b0; s8_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s8_in_valid = 1'b0;
    lat = 1;
    while (!s8_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== LAT8) begin
      failures++;
      $display("FAIL w8_latency: got %0d want %0d", lat, LAT8);
    end
    checks++;
    if (s8_out_q !== 8'd28 || s8_out_r !== 8'd4 || s8_out_dbz !== 1'b0) begin
      failures++;
      $display("FAIL w8_result: got q=%0d r=%0d dbz=%b want 28 4 0", s8_out_q, s8_out_r, s8_out_dbz);
    end
    @(negedge clk);
    s8_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s8_out_ready = 1'b0;
    checks++;
    if (s8_out_valid !== 1'b0 || s8_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL w8_release: got valid=%b ready=%b want 0 1", s8_out_valid, s8_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit saw;
    // Consumer always ready: result accepted the edge after it appears.
    out_ready = 1'b1;
    start32(32'd81, 32'd9, 1'b0);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'd9 || out_r !== 32'd0) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want 33 9 0", lat, out_q, out_r);
    end
    @(posedge clk);
    #1;
    start32(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    wait32(lat, saw);
    checks++;
    if (lat !== LAT32 || out_q !== 32'd14 || out_r !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h want 33 e fffffffe", lat, out_q, out_r);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    s8_in_valid = 1'b0; s8_in_a = '0; s8_in_b = '0; s8_in_signed = 1'b0; s8_out_ready = 1'b0;

    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_backpressure();
    test_reset_mid_calc();
    test_early_term();
    test_width8();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
